// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic MULDIV_OP_MULT = 1'b0;
  localparam logic MULDIV_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, arithmetic-unit and HI/LO steering signals of the MULT/DIV sequencer.
// slave: the sequencer; master: control FSM plus multiplier/divider side.
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic              req_valid;
  logic              req_op;
  logic              req_ready;
  logic [DATA_W-1:0] divisor;
  logic              mult_start;
  logic              mult_end;
  logic              div_start;
  logic              div_end;
  logic              hi_ctrl;
  logic              lo_ctrl;
  logic              hilo_write;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic              hilo_rd_req;
  logic              stall;
  logic              timeout;

  modport slave (
    input  req_valid, req_op, divisor, mult_end, div_end, hilo_rd_req,
    output req_ready, mult_start, div_start, hi_ctrl, lo_ctrl,
           hilo_write, busy, done, div_zero, stall, timeout
  );

  modport master (
    output req_valid, req_op, divisor, mult_end, div_end, hilo_rd_req,
    input  req_ready, mult_start, div_start, hi_ctrl, lo_ctrl,
           hilo_write, busy, done, div_zero, stall, timeout
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// RUN-cycle counter; expire_c flags the cycle in which the count reaches MAX_CYCLES.
module muldiv_watchdog #(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt_q;

  // Clear on entry to RUN, count every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = en && (cnt_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiplier/divider: start pulse, wait for end,
// steer HI/LO muxes and load them once. Raises divide-by-zero before a DIV
// starts and stalls MFHI/MFLO while busy.
// Optional RUN watchdog compiled in with MULDIV_WATCHDOG_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned CNT_W      = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_ctrl_if.slave  bus
);

  // Elaboration guard: the watchdog limit must fit the counter.
  if (64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_cfg_check
    $error("muldiv_ctrl: MAX_CYCLES must be below 2**CNT_W");
  end

  state_t state_q, state_d;
  logic   op_q, op_d;
  logic   div_zero_q, div_zero_d;
  logic   end_sel_c;
  logic   expire_c;

  assign end_sel_c = (op_q == MULDIV_OP_DIV) ? bus.div_end : bus.mult_end;

  // Next-state decode; end signals are only looked at in RUN.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == MULDIV_OP_DIV && bus.divisor == '0) begin
            div_zero_d = 1'b1;
          end else begin
            op_d    = bus.req_op;
            state_d = START;
          end
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (end_sel_c) begin
          state_d = WRITE;
        end else if (expire_c) begin
          state_d = IDLE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched op and exception register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= MULDIV_OP_MULT;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      div_zero_q <= div_zero_d;
    end
  end

`ifdef MULDIV_WATCHDOG_EN
  logic timeout_q;

  muldiv_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == START),
    .en       (state_q == RUN),
    .expire_c (expire_c)
  );

  // An end arriving with the limit wins; timeout only on a true expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == RUN) && !end_sel_c && expire_c;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire_c    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Outputs decoded from the state register.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.mult_start = (state_q == START) && (op_q == MULDIV_OP_MULT);
  assign bus.div_start  = (state_q == START) && (op_q == MULDIV_OP_DIV);
  assign bus.hi_ctrl    = (state_q != IDLE) && op_q;
  assign bus.lo_ctrl    = (state_q != IDLE) && op_q;
  assign bus.hilo_write = (state_q == WRITE);
  assign bus.done       = (state_q == WRITE);
  assign bus.div_zero   = div_zero_q;
  assign bus.stall      = bus.hilo_rd_req && (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver issues requests and pushes the
// expected start pulse and completion event; a negedge monitor pops and compares.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int EV_WR = 0;
  localparam int EV_DZ = 1;
  localparam int EV_TO = 2;

  typedef struct {
    int   kind;
    logic op;
    int   cyc;
  } ev_t;

  typedef struct {
    logic op;
    int   cyc;
  } st_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_en = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_op = 1'b0;
  ev_t  evq[$];
  st_t  stq[$];

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endfunction

  function automatic logic [3:0] ev_pattern(input int kind);
    case (kind)
      EV_WR:   return 4'b1100;
      EV_DZ:   return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  // Monitor: per-cycle status against the model, event pulses against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      st_t st;
      ev_t ev;
      logic [3:0] evsig;
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy));
      chk("hi_ctrl", 32'(bus.hi_ctrl), 32'(exp_busy & exp_op));
      chk("lo_ctrl", 32'(bus.lo_ctrl), 32'(exp_busy & exp_op));
      chk("stall", 32'(bus.stall), 32'(bus.hilo_rd_req & exp_busy));
      if (bus.mult_start || bus.div_start) begin
        if (stq.size() == 0) begin
          chk("start_spurious", 32'({bus.mult_start, bus.div_start}), 32'd0);
        end else begin
          st = stq.pop_front();
          chk("start_cycle", 32'(cyc), 32'(st.cyc));
          chk("start_sel", 32'({bus.mult_start, bus.div_start}), st.op ? 32'd1 : 32'd2);
        end
      end else if (stq.size() > 0 && stq[0].cyc < cyc) begin
        st = stq.pop_front();
        chk("start_missing", 32'(cyc), 32'(st.cyc));
      end
      evsig = {bus.hilo_write, bus.done, bus.div_zero, bus.timeout};
      if (evsig != 4'b0000) begin
        if (evq.size() == 0) begin
          chk("event_spurious", 32'(evsig), 32'd0);
        end else begin
          ev = evq.pop_front();
          chk("event_cycle", 32'(cyc), 32'(ev.cyc));
          chk("event_kind", 32'(evsig), 32'(ev_pattern(ev.kind)));
        end
      end else if (evq.size() > 0 && evq[0].cyc < cyc) begin
        ev = evq.pop_front();
        chk("event_missing", 32'(cyc), 32'(ev.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.hilo_rd_req = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_ends(input logic op, input logic sel, input logic oth);
    if (op == MULDIV_OP_DIV) begin
      bus.div_end  = sel;
      bus.mult_end = oth;
    end else begin
      bus.mult_end = sel;
      bus.div_end  = oth;
    end
  endtask

  // One request from an idle DUT; lat = cycles from start pulse to the unit end.
  task automatic run_op(input logic op, input logic [31:0] dv, input int lat,
                        input bit early, input bit noise);
    int a;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.divisor   = dv;
    step();
    a = cyc;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'($urandom);
    bus.divisor   = $urandom;
    if (op == MULDIV_OP_DIV && dv == 32'd0) begin
      evq.push_back('{EV_DZ, 1'b0, a});
      return;
    end
    exp_busy = 1'b1;
    exp_op   = op;
    stq.push_back('{op, a});
    evq.push_back('{EV_WR, op, a + lat + 1});
    drive_ends(op, early, noise ? 1'($urandom_range(0, 1)) : 1'b0);
    for (int k = 1; k <= lat; k++) begin
      step();
      drive_ends(op, k == lat, noise ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.req_valid = (noise && k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.req_op    = 1'($urandom);
      bus.divisor   = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
    end
    step();
    drive_ends(op, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    step();
    exp_busy = 1'b0;
  endtask

  // DIV with an early end during START, then reset in RUN: no load may follow.
  task automatic reset_mid_run();
    int a;
    bus.req_valid = 1'b1;
    bus.req_op    = MULDIV_OP_DIV;
    bus.divisor   = 32'd7;
    step();
    a = cyc;
    bus.req_valid = 1'b0;
    exp_busy = 1'b1;
    exp_op   = MULDIV_OP_DIV;
    stq.push_back('{MULDIV_OP_DIV, a});
    drive_ends(MULDIV_OP_DIV, 1'b1, 1'b0);
    step();
    drive_ends(MULDIV_OP_DIV, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_busy = 1'b0;
    repeat (4) step();
  endtask

`ifdef MULDIV_WATCHDOG_EN
  // MULT whose end never arrives: timeout 40 RUN cycles after entering RUN.
  task automatic watchdog_expiry();
    int a;
    bus.req_valid = 1'b1;
    bus.req_op    = MULDIV_OP_MULT;
    bus.divisor   = 32'd3;
    step();
    a = cyc;
    bus.req_valid = 1'b0;
    exp_busy = 1'b1;
    exp_op   = MULDIV_OP_MULT;
    stq.push_back('{MULDIV_OP_MULT, a});
    evq.push_back('{EV_TO, 1'b0, a + 41});
    drive_ends(MULDIV_OP_MULT, 1'b0, 1'b0);
    repeat (40) step();
    step();
    exp_busy = 1'b0;
    repeat (3) step();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    logic       op;
    logic [31:0] dv;
    bus.req_valid   = 1'b0;
    bus.req_op      = 1'b0;
    bus.divisor     = 32'd0;
    bus.mult_end    = 1'b0;
    bus.div_end     = 1'b0;
    bus.hilo_rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    run_op(MULDIV_OP_MULT, $urandom, 32, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV, 32'd7, 33, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV, 32'd0, 0, 1'b0, 1'b0);
    run_op(MULDIV_OP_MULT, $urandom, 32, 1'b0, 1'b1);
    run_op(MULDIV_OP_DIV, 32'd1, 1, 1'b1, 1'b1);
    run_op(MULDIV_OP_MULT, 32'd0, 40, 1'b1, 1'b0);
    run_op(MULDIV_OP_DIV, 32'hFFFF_FFFF, 40, 1'b0, 1'b1);
    run_op(MULDIV_OP_DIV, 32'd0, 0, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV, 32'd0, 0, 1'b0, 1'b0);
    reset_mid_run();
`ifdef MULDIV_WATCHDOG_EN
    watchdog_expiry();
`endif

    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom);
      dv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(op, dv, $urandom_range(1, 40), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) step();
      end
    end

    repeat (5) step();
    chk("start_queue_drained", 32'(stq.size()), 32'd0);
    chk("event_queue_drained", 32'(evq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
